// File: rtl/bus_pkg.sv
// Shared types for the arbitrated command bus: command encoding, beat payload
// and arbiter state encoding.
package bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10
  } bus_cmd_e;

  localparam int CMD_W = $bits(bus_cmd_e);

  typedef struct packed {
    bus_cmd_e            cmd;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } bus_beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Initiator-side request bundle and registered bus-side outputs of the arbiter.
// master = initiator agents, slave = the arbiter itself.
interface bus_arbiter_if #(
  parameter int N_REQ = 4
);
  import bus_pkg::*;

  logic [N_REQ-1:0]              req;
  logic [N_REQ-1:0]              lock;
  logic [N_REQ-1:0][CMD_W-1:0]   cmd_i;
  logic [N_REQ-1:0][ADDR_W-1:0]  addr_i;
  logic [N_REQ-1:0][DATA_W-1:0]  data_i;

  logic [N_REQ-1:0]              gnt;
  bus_cmd_e                      bus_cmd;
  logic [ADDR_W-1:0]             bus_addr;
  logic [DATA_W-1:0]             bus_data;
  logic [$clog2(N_REQ)-1:0]      bus_owner;

  modport master (
    output req, lock, cmd_i, addr_i, data_i,
    input  gnt, bus_cmd, bus_addr, bus_data, bus_owner
  );

  modport slave (
    input  req, lock, cmd_i, addr_i, data_i,
    output gnt, bus_cmd, bus_addr, bus_data, bus_owner
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping
// from N_REQ-1 to 0.
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared registered command bus with capped locked
// bursts; owner changes happen on the releasing edge so no bubble is inserted.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arb_state_e        state, state_n;
  logic [PTR_W-1:0]  owner, owner_n;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
  logic [N_REQ-1:0]  gnt, gnt_n;
  bus_beat_t         beat_q, beat_n;

  logic [PTR_W-1:0]  owner_inc;
  logic [PTR_W-1:0]  pick_ptr;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              beat;
  logic              rel;

  assign owner_inc = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  // On release the search starts just past the old owner, making it lowest priority.
  assign pick_ptr  = (state == ST_OWN) ? owner_inc : rr_ptr;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign beat = (state == ST_OWN) && bus.req[owner];
  assign rel  = (state == ST_OWN) &&
                (!bus.req[owner] || !bus.lock[owner] || (beat_cnt == LAST_BEAT));

  always_comb begin
    state_n    = state;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    gnt_n      = gnt;
    beat_n     = beat_q;
    beat_n.cmd = BUS_IDLE;

    if (beat) begin
      beat_n.cmd  = bus_cmd_e'(bus.cmd_i[owner]);
      beat_n.addr = bus.addr_i[owner];
      beat_n.data = bus.data_i[owner];
      beat_cnt_n  = beat_cnt + 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_n       = pick_idx;
          gnt_n         = '0;
          gnt_n[pick_idx] = 1'b1;
          beat_cnt_n    = '0;
          state_n       = ST_OWN;
        end
      end
      ST_OWN: begin
        if (rel) begin
          rr_ptr_n   = owner_inc;
          beat_cnt_n = '0;
          gnt_n      = '0;
          if (pick_vld) begin
            owner_n         = pick_idx;
            gnt_n[pick_idx] = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      beat_q   <= '{cmd: BUS_IDLE, addr: '0, data: '0};
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      gnt      <= gnt_n;
      beat_q   <= beat_n;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.bus_cmd   = beat_q.cmd;
  assign bus.bus_addr  = beat_q.addr;
  assign bus.bus_data  = beat_q.data;
  assign bus.bus_owner = owner;

endmodule
